// File: rtl/bitwise_lu_pkg.sv
// Shared definitions for the bitwise logic unit pipeline: op encoding and default sizes.
package bitwise_lu_pkg;

   localparam int unsigned WIDTH_DEFAULT = 32;
   localparam int unsigned DEPTH_DEFAULT = 4;

   typedef enum logic [2:0] {
      OP_INV  = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_XNOR = 3'd4,
      OP_NAND = 3'd5,
      OP_NOR  = 3'd6,
      OP_BUF  = 3'd7
   } op_e;

endpackage

// File: rtl/bitwise_lu_fifo.sv
// Result buffer for bitwise_lu_pipe: DEPTH-entry FIFO with ready/valid on both sides.
// wr_ready is held in a register so it never depends on rd_ready and is low during reset.
module bitwise_lu_fifo #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [DW-1:0]              wr_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [DW-1:0]              rd_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ready_q;
   logic          push, pop;

   assign rd_valid = (count_q != '0);
   assign wr_ready = wr_ready_q;
   assign push     = wr_valid & wr_ready_q;
   assign pop      = rd_valid & rd_ready;
   assign rd_data  = mem[rd_ptr_q];
   assign count    = count_q;

   // Next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer, occupancy and ready state; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wr_ready_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q    <= count_d;
         wr_ready_q <= (count_d != CW'(DEPTH));
      end
   end

   // Storage write; contents need no reset because reads are qualified by rd_valid.
   always_ff @(posedge clk) begin
      if (push && !reset) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/bitwise_lu_pipe.sv
// Bitwise logic unit with a buffered result stream.
// Macro BITWISE_LU_FLAGS_EN: when defined, zero/parity flags are computed at input time and
// stored with each result; when undefined, the flags are tied low and no flag storage exists.
module bitwise_lu_pipe
   import bitwise_lu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 op,
   input  logic [WIDTH-1:0]           a,
   input  logic [WIDTH-1:0]           b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           y,
   output logic                       zero,
   output logic                       parity,
   output logic [$clog2(DEPTH):0]     count
);

`ifdef BITWISE_LU_FLAGS_EN
   localparam int unsigned DW = WIDTH + 2;
`else
   localparam int unsigned DW = WIDTH;
`endif

   logic [WIDTH-1:0] res;
   logic [DW-1:0]    wr_data, rd_data;

   // Op decode; b is unused by INV and BUF.
   always_comb begin
      res = '0;
      unique case (op_e'(op))
         OP_INV:  res = ~a;
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_XNOR: res = ~(a ^ b);
         OP_NAND: res = ~(a & b);
         OP_NOR:  res = ~(a | b);
         OP_BUF:  res = a;
         default: res = '0;
      endcase
   end

`ifdef BITWISE_LU_FLAGS_EN
   // Stored layout: {zero, parity, result}.
   assign wr_data = {~|res, ^res, res};
   assign y       = out_valid ? rd_data[WIDTH-1:0] : '0;
   assign zero    = out_valid & rd_data[WIDTH+1];
   assign parity  = out_valid & rd_data[WIDTH];
`else
   assign wr_data = res;
   assign y       = out_valid ? rd_data : '0;
   assign zero    = 1'b0;
   assign parity  = 1'b0;
`endif

   bitwise_lu_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_valid (in_valid),
      .wr_ready (in_ready),
      .wr_data  (wr_data),
      .rd_valid (out_valid),
      .rd_ready (out_ready),
      .rd_data  (rd_data),
      .count    (count)
   );

endmodule

// File: tb/tb_bitwise_lu_pipe.sv
// Directed self-checking bench for bitwise_lu_pipe at WIDTH=8, DEPTH=4.
module tb_bitwise_lu_pipe;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] op = 3'd0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] y;
   logic       zero;
   logic       parity;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;

`ifdef BITWISE_LU_FLAGS_EN
   localparam bit FlagsOn = 1'b1;
`else
   localparam bit FlagsOn = 1'b0;
`endif

   bitwise_lu_pipe #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .parity    (parity),
      .count     (count)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (y !== 8'h00) begin errors++; $display("FAIL rst_y got %h want 00", y); end
      checks++; if ({zero, parity} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {zero, parity}); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
      reset = 1'b0;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid = 1'b1; op = 3'd1; a = 8'hF0; b = 8'h3C;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %b want 1", out_valid); end
      checks++; if (y !== 8'h30) begin errors++; $display("FAIL single_y got %h want 30", y); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
      step();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_drain_count got %0d want 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b want 0", out_valid); end
   endtask

   task automatic test_all_ops();
      logic [7:0] exp_y [8];
      exp_y = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'h55, 8'hFA, 8'h50, 8'hA5};
      out_ready = 1'b1;
      a = 8'hA5; b = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; op = 3'(i);
         step();
         checks++;
         if (out_valid !== 1'b1 || y !== exp_y[i]) begin
            errors++;
            $display("FAIL ops_%0d got valid=%b y=%h want valid=1 y=%h", i, out_valid, y, exp_y[i]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL ops_drain_count got %0d want 0", count); end
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      op = 3'd7; b = 8'h00;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; a = 8'(i + 1);
         step();
         if (i == 3) begin
            checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
         end
      end
      in_valid = 1'b0;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_fifth_count got %0d want 4", count); end
      checks++; if (y !== 8'h01) begin errors++; $display("FAIL full_head got %h want 01", y); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_in_ready got %b want 1", in_ready); end
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", count); end
      out_ready = 1'b1;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (y !== 8'(j + 2)) begin errors++; $display("FAIL full_drain_%0d got %h want %h", j, y, 8'(j + 2)); end
         step();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drain_valid got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      op = 3'd7; b = 8'h00;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; a = 8'(8'h10 + i);
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; a = 8'(8'h12 + i);
         checks++;
         if (y !== 8'(8'h10 + i)) begin errors++; $display("FAIL b2b_head_%0d got %h want %h", i, y, 8'(8'h10 + i)); end
         step();
         checks++;
         if (count !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d got %0d want 2", i, count); end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (y !== 8'(8'h1A + i)) begin errors++; $display("FAIL b2b_tail_%0d got %h want %h", i, y, 8'(8'h1A + i)); end
         step();
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_drain_count got %0d want 0", count); end
   endtask

   task automatic test_flags();
      out_ready = 1'b0;
      op = 3'd3; a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
      step();
      op = 3'd3; a = 8'h0F; b = 8'h0E;
      step();
      in_valid = 1'b0;
      checks++; if (y !== 8'h00) begin errors++; $display("FAIL flags_y0 got %h want 00", y); end
      checks++;
      if ({zero, parity} !== {FlagsOn, 1'b0}) begin
         errors++; $display("FAIL flags_zp0 got %b want %b", {zero, parity}, {FlagsOn, 1'b0});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (y !== 8'h01) begin errors++; $display("FAIL flags_y1 got %h want 01", y); end
      checks++;
      if ({zero, parity} !== {1'b0, FlagsOn}) begin
         errors++; $display("FAIL flags_zp1 got %b want %b", {zero, parity}, {1'b0, FlagsOn});
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      op = 3'd7;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 8'(8'h40 + i);
         step();
      end
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", count); end
      // Both handshakes offered during reset; neither may take effect.
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_post_count got %0d want 0", count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_ops();
      test_full();
      test_back_to_back();
      test_flags();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
